// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the five-stage pipeline.
// Holds the PC, drives the instruction-memory address, picks the next PC
// (reset > branch > jump > sequential > hold) and registers the fetched
// word into the IF/ID pipeline register. A redirect from decode always
// reloads the PC and flushes IF/ID, even when a load-use stall is requested.
//
// Optional build macro: IF_PERF_CNT_EN adds saturating 32-bit stall/flush
// cycle counters (stall_cycles, flush_cycles). Without it, fetch behaviour
// is identical and the counter ports do not exist.

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_IFWrite,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_id,
  output logic [31:0] pc4_id,
  output logic [31:0] instr_id,
  output logic        valid_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        redirect;

  // imem_addr comes straight from the PC flop: no input-to-address path.
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign redirect  = branch_taken | jump;

  // Next-PC select; targets are word-aligned by dropping the low two bits.
  always_comb begin
    pc_next = pc;
    if (branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (jump) begin
      pc_next = {jump_target[31:2], 2'b00};
    end else if (PC_IFWrite) begin
      pc_next = pc_plus4;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // IF/ID register: flush on reset/redirect, load on write-enable, else hold.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      instr_id <= NOP;
      pc_id    <= 32'h0;
      pc4_id   <= 32'h0;
      valid_id <= 1'b0;
    end else if (PC_IFWrite) begin
      instr_id <= imem_data;
      pc_id    <= pc;
      pc4_id   <= pc_plus4;
      valid_id <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Stall counter: cycles where the hazard unit froze fetch and no redirect occurred.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'h0;
    end else if (!redirect && !PC_IFWrite && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  // Flush counter: one per redirect cycle, a simultaneous branch+jump counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cycles <= 32'h0;
    end else if (redirect && (flush_cycles != 32'hFFFF_FFFF)) begin
      flush_cycles <= flush_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed self-checking bench for if_fetch_stage.
// Instance u_dut uses RESET_PC=0; u_dut_wrap uses RESET_PC=FFFF_FFF8 to
// exercise PC+4 wraparound. Counter checks are compiled in with IF_PERF_CNT_EN.

module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        PC_IFWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_id;
  logic [31:0] pc4_id;
  logic [31:0] instr_id;
  logic        valid_id;

  logic        rst_w;
  logic        we_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_data_w;
  logic [31:0] pc_id_w;
  logic [31:0] pc4_id_w;
  logic [31:0] instr_id_w;
  logic        valid_id_w;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
  logic [31:0] stall_cycles_w;
  logic [31:0] flush_cycles_w;
`endif

  int total;
  int bad;

  localparam logic [31:0] TAG = 32'hA5A5_0000;

  assign imem_data   = imem_addr ^ TAG;
  assign imem_data_w = imem_addr_w ^ TAG;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .PC_IFWrite   (PC_IFWrite),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc_id        (pc_id),
    .pc4_id       (pc4_id),
    .instr_id     (instr_id),
    .valid_id     (valid_id)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP(32'h0000_0000)) u_dut_wrap (
    .clk          (clk),
    .rst          (rst_w),
    .PC_IFWrite   (we_w),
    .branch_taken (1'b0),
    .branch_target(32'h0),
    .jump         (1'b0),
    .jump_target  (32'h0),
    .imem_addr    (imem_addr_w),
    .imem_data    (imem_data_w),
    .pc_id        (pc_id_w),
    .pc4_id       (pc4_id_w),
    .instr_id     (instr_id_w),
    .valid_id     (valid_id_w)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles_w),
    .flush_cycles (flush_cycles_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] addr, input logic [31:0] pcid,
                          input logic [31:0] ins, input logic vld);
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".pc_id"}, pc_id, pcid);
    chk({tag, ".pc4_id"}, pc4_id, vld ? pcid + 32'd4 : 32'h0);
    chk({tag, ".instr_id"}, instr_id, ins);
    chk({tag, ".valid_id"}, {31'h0, valid_id}, {31'h0, vld});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; PC_IFWrite = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0;
    rst_w = 1'b1; we_w = 1'b1;

    step(); step();
    chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("reset.stall", stall_cycles, 32'h0);
    chk("reset.flush", flush_cycles, 32'h0);
`endif

    // free run
    rst = 1'b0;
    chk("run0.imem_addr", imem_addr, 32'h0);
    step(); chk_ifid("run1", 32'h4,  32'h0, 32'hA5A5_0000, 1'b1);
    step(); chk_ifid("run2", 32'h8,  32'h4, 32'hA5A5_0004, 1'b1);
    step(); chk_ifid("run3", 32'hC,  32'h8, 32'hA5A5_0008, 1'b1);
    step(); chk_ifid("run4", 32'h10, 32'hC, 32'hA5A5_000C, 1'b1);

    // two-cycle stall at PC=0x10
    PC_IFWrite = 1'b0;
    step(); chk_ifid("stall1", 32'h10, 32'hC, 32'hA5A5_000C, 1'b1);
    step(); chk_ifid("stall2", 32'h10, 32'hC, 32'hA5A5_000C, 1'b1);
`ifdef IF_PERF_CNT_EN
    chk("stall2.stall", stall_cycles, 32'd2);
`endif
    PC_IFWrite = 1'b1;
    step(); chk_ifid("rel1", 32'h14, 32'h10, 32'hA5A5_0010, 1'b1);
    step(); chk_ifid("rel2", 32'h18, 32'h14, 32'hA5A5_0014, 1'b1);
    step(); chk_ifid("rel3", 32'h1C, 32'h18, 32'hA5A5_0018, 1'b1);
    step(); chk_ifid("rel4", 32'h20, 32'h1C, 32'hA5A5_001C, 1'b1);

    // taken branch, misaligned target
    branch_taken = 1'b1; branch_target = 32'h0000_0203;
    step(); chk_ifid("br1", 32'h200, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("br1.flush", flush_cycles, 32'd1);
`endif
    branch_taken = 1'b0;
    step(); chk_ifid("br2", 32'h204, 32'h200, 32'hA5A5_0200, 1'b1);

    // branch + jump + stall together: branch wins, one flush, no stall
    branch_taken = 1'b1; branch_target = 32'h100;
    jump = 1'b1; jump_target = 32'h300; PC_IFWrite = 1'b0;
    step(); chk_ifid("bj", 32'h100, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("bj.flush", flush_cycles, 32'd2);
    chk("bj.stall", stall_cycles, 32'd2);
`endif
    branch_taken = 1'b0; jump = 1'b0; PC_IFWrite = 1'b1;

    // back-to-back jumps, then a stall, then release
    jump = 1'b1; jump_target = 32'h401;
    step(); chk_ifid("jj1", 32'h400, 32'h0, 32'h0, 1'b0);
    jump_target = 32'h500;
    step(); chk_ifid("jj2", 32'h500, 32'h0, 32'h0, 1'b0);
    jump = 1'b0; PC_IFWrite = 1'b0;
    step(); chk_ifid("jj3", 32'h500, 32'h0, 32'h0, 1'b0);
    PC_IFWrite = 1'b1;
    step(); chk_ifid("jj4", 32'h504, 32'h500, 32'hA5A5_0500, 1'b1);
`ifdef IF_PERF_CNT_EN
    chk("jj4.flush", flush_cycles, 32'd4);
    chk("jj4.stall", stall_cycles, 32'd3);
`endif

    // reset while stalling and with a redirect pending
    PC_IFWrite = 1'b0;
    step();
`ifdef IF_PERF_CNT_EN
    chk("pre_rst.stall", stall_cycles, 32'd4);
`endif
    rst = 1'b1; jump = 1'b1; jump_target = 32'h800;
    step(); chk_ifid("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("rst2.stall", stall_cycles, 32'h0);
    chk("rst2.flush", flush_cycles, 32'h0);
`endif
    rst = 1'b0; jump = 1'b0; PC_IFWrite = 1'b1;
    step(); chk_ifid("after_rst", 32'h4, 32'h0, 32'hA5A5_0000, 1'b1);

    // wraparound instance
    chk("wrap0.imem_addr", imem_addr_w, 32'hFFFF_FFF8);
    rst_w = 1'b0;
    step(); chk("wrap1.imem_addr", imem_addr_w, 32'hFFFF_FFFC);
    step(); chk("wrap2.imem_addr", imem_addr_w, 32'h0000_0000);
    chk("wrap2.pc_id", pc_id_w, 32'hFFFF_FFFC);
    chk("wrap2.pc4_id", pc4_id_w, 32'h0000_0000);
    chk("wrap2.instr_id", instr_id_w, 32'h5A5A_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
